// File: rtl/seg_issue_ctrl.sv
// seg_issue_ctrl: front-end sequencer for the piecewise-polynomial datapath.
// Takes a 32-bit uniform word and normalises its 31-bit magnitude field one
// bit per cycle to find a segment address and a fraction. It then issues one
// evaluation, waits for the result, applies the sign bit and hands a signed
// 17-bit sample downstream. Samples never overlap.
module seg_issue_ctrl #(
  parameter int LZ_MAX = 31,
  parameter int DP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] u_data,
  input  logic        u_valid,
  output logic        u_ready,
  output logic [6:0]  dp_segment,
  output logic [14:0] dp_dataa,
  output logic        dp_en,
  input  logic [15:0] dp_result,
  input  logic        dp_done,
  output logic [16:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NORM  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam int WCNT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(DP_LAT - 1);
  localparam logic [4:0] LZ_CAP = 5'(LZ_MAX);

  logic [2:0]        state_q, state_d;
  logic              sgn_q, sgn_d;
  logic [30:0]       mant_q, mant_d;
  logic [4:0]        lz_q, lz_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [6:0]        seg_q, seg_d;
  logic [14:0]       dataa_q, dataa_d;
  logic [16:0]       out_data_q, out_data_d;

  // Next-state logic: every register holds unless its state says otherwise.
  // The wait counter saturates at DP_LAT-1, so a late dp_done is caught on
  // the cycle after it rises, with no timeout.
  always_comb begin
    state_d    = state_q;
    sgn_d      = sgn_q;
    mant_d     = mant_q;
    lz_d       = lz_q;
    wcnt_d     = wcnt_q;
    seg_d      = seg_q;
    dataa_d    = dataa_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (u_valid) begin
          sgn_d   = u_data[31];
          mant_d  = u_data[30:0];
          lz_d    = 5'd0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mant_q[30] || (lz_q == LZ_CAP)) begin
          seg_d   = {lz_q, mant_q[29:28]};
          dataa_d = mant_q[27:13];
          state_d = S_ISSUE;
        end else begin
          mant_d = {mant_q[29:0], 1'b0};
          lz_d   = lz_q + 5'd1;
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WCNT_LAST) begin
          if (dp_done) begin
            out_data_d = sgn_q ? (17'h0 - {1'b0, dp_result}) : {1'b0, dp_result};
            state_d    = S_OUT;
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any sample in flight at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sgn_q      <= 1'b0;
      mant_q     <= '0;
      lz_q       <= '0;
      wcnt_q     <= '0;
      seg_q      <= '0;
      dataa_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      sgn_q      <= sgn_d;
      mant_q     <= mant_d;
      lz_q       <= lz_d;
      wcnt_q     <= wcnt_d;
      seg_q      <= seg_d;
      dataa_q    <= dataa_d;
      out_data_q <= out_data_d;
    end
  end

  assign u_ready    = (state_q == S_IDLE);
  assign dp_en      = (state_q == S_ISSUE);
  assign out_valid  = (state_q == S_OUT);
  assign dp_segment = seg_q;
  assign dp_dataa   = dataa_q;
  assign out_data   = out_data_q;

endmodule
